alu_mul_sequencer: RTL and testbench

Multi-cycle controller that owns the pipeline's 64-bit ALU and time-shares it between the execute stage and an iterative shift-add multiplier. When idle, the execute stage's operands and ALUOp pass straight through to the ALU. On a multiply request, the block stalls the pipeline and sequences the ALU through ADD (ALUOp 4'b0010) and SLLI (ALUOp 4'b0101) operations to form the low 64 bits of a×b. It sits between the ID/EX register and the ALU in the 2.5-stage pipeline.

---
 rtl/alu_mul_sequencer.sv | 101 ++++++++++
 tb/tb_alu_mul_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Time-shares the pipeline ALU between the execute stage and an iterative
// shift-add multiplier that forms the low 64 bits of a*b.
module alu_mul_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pipe_a,
  input  logic [63:0] pipe_b,
  input  logic [3:0]  pipe_op,
  input  logic        start,
  input  logic [63:0] alu_result,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [3:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLLI = 4'b0101;

  state_t      state, state_nxt;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [63:0] mplier;
  logic [6:0]  cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= pipe_a;
            mplier <= pipe_b;
            cnt    <= '0;
          end
        end
        S_ADD: begin
          if (mplier[0]) acc <= alu_result;
        end
        S_SHIFT: begin
          mcand  <= alu_result;
          mplier <= mplier >> 1;
          cnt    <= cnt + 7'd1;
        end
        S_DONE: product <= acc;
        default: ;
      endcase
    end
  end

  // Passthrough is the default; only ADD/SHIFT take the ALU over.
  always_comb begin
    state_nxt = state;
    alu_a     = pipe_a;
    alu_b     = pipe_b;
    alu_op    = pipe_op;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (pipe_b != '0) ? S_ADD : S_DONE;
      end
      S_ADD: begin
        alu_a     = acc;
        alu_b     = mcand;
        alu_op    = OP_ADD;
        busy      = 1'b1;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        alu_a  = mcand;
        alu_b  = 64'd1;
        alu_op = OP_SLLI;
        busy   = 1'b1;
        if (((mplier >> 1) == '0) || (cnt == 7'd63)) state_nxt = S_DONE;
        else                                        state_nxt = S_ADD;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU plus a product/latency scoreboard.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pipe_a, pipe_b;
  logic [3:0]  pipe_op;
  logic        start;
  logic [63:0] alu_result;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        busy, done;
  logic [63:0] product;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb_q[$];
  int          lat_q[$];

  alu_mul_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_a     (pipe_a),
    .pipe_b     (pipe_b),
    .pipe_op    (pipe_op),
    .start      (start),
    .alu_result (alu_result),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .busy       (busy),
    .done       (done),
    .product    (product)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0101: alu_result = alu_a << alu_b[5:0];
      4'b0110: alu_result = alu_a - alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int msb_k(input logic [63:0] b);
    for (int i = 63; i >= 0; i--)
      if (b[i]) return i + 1;
    return 0;
  endfunction

  task automatic run_mul(input logic [63:0] a, input logic [63:0] b);
    int          n;
    int          busy_cyc;
    int          exp_l;
    logic [63:0] prev;
    logic [63:0] exp_p;
    @(negedge clk);
    pipe_a = a; pipe_b = b; pipe_op = 4'b0110; start = 1'b1;
    prev = product;
    sb_q.push_back(a * b);
    lat_q.push_back(2 * msb_k(b));
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n = 0; busy_cyc = 0;
    while (!done && n < 200) begin
      if (busy) begin
        busy_cyc++;
        check_eq("op_seq", {60'd0, alu_op}, n[0] ? 64'd5 : 64'd2);
        check_eq("hold_busy", product, prev);
      end
      @(negedge clk);
      n++;
    end
    exp_p = sb_q.pop_front();
    exp_l = lat_q.pop_front();
    check_eq("latency", n, exp_l);
    check_eq("busy_cycles", busy_cyc, exp_l);
    check_eq("busy_in_done", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check_eq("done_pulse", {63'd0, done}, 64'd0);
    check_eq("product", product, exp_p);
  endtask

  initial begin
    int          n;
    logic [63:0] exp_p;
    reset = 1'b0; start = 1'b0;
    pipe_a = '0; pipe_b = '0; pipe_op = '0;
    #12;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_product", product, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_mul(64'd3, 64'd5);
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    run_mul(64'h1234, 64'd0);
    run_mul(64'd3, 64'h8000_0000_0000_0000);
    run_mul({$urandom, $urandom}, {32'd0, $urandom});
    run_mul({$urandom, $urandom}, {$urandom, $urandom});

    // Passthrough while idle
    @(negedge clk);
    pipe_a = 64'd7; pipe_b = 64'd9; pipe_op = 4'b0011;
    #1;
    check_eq("pass_a", alu_a, 64'd7);
    check_eq("pass_b", alu_b, 64'd9);
    check_eq("pass_op", {60'd0, alu_op}, 64'd3);

    // Start while busy and during done must be ignored
    @(negedge clk);
    pipe_a = 64'd5; pipe_b = 64'd6; start = 1'b1;
    sb_q.push_back(64'd30);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    pipe_a = 64'd100; pipe_b = 64'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_done_seen", {63'd0, done}, 64'd1);
    pipe_b = 64'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_p = sb_q.pop_front();
    check_eq("start_in_done_ignored", {63'd0, busy}, 64'd0);
    check_eq("mid_start_product", product, exp_p);

    // Asynchronous reset mid-multiply
    @(negedge clk);
    pipe_a = 64'd10; pipe_b = 64'd255; pipe_op = 4'b0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_busy", {63'd0, busy}, 64'd1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_busy", {63'd0, busy}, 64'd0);
    check_eq("async_done", {63'd0, done}, 64'd0);
    check_eq("async_product", product, 64'd0);
    check_eq("async_pass_op", {60'd0, alu_op}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    run_mul(64'd10, 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
